// File: rtl/me_sad_selector_if.sv
// Handshake/bus bundle between the ME adder tree, the SAD selector and mode decision.
//   start, sad_valid, sad  : producer -> selector (search control and candidate SADs)
//   mv_ready               : consumer -> selector (result accept)
//   busy, mv_valid, mv_x, mv_y, min_sad : selector -> consumer (status and result)
// modport slave is the selector side; modport master is the driving side.
interface me_sad_selector_if #(
    parameter int unsigned SAD_W = 16,
    parameter int unsigned MV_W  = 6
) ();
    logic                    start;
    logic                    sad_valid;
    logic [SAD_W-1:0]        sad;
    logic                    busy;
    logic                    mv_valid;
    logic                    mv_ready;
    logic signed [MV_W-1:0]  mv_x;
    logic signed [MV_W-1:0]  mv_y;
    logic [SAD_W-1:0]        min_sad;

    modport slave (
        input  start, sad_valid, sad, mv_ready,
        output busy, mv_valid, mv_x, mv_y, min_sad
    );

    modport master (
        output start, sad_valid, sad, mv_ready,
        input  busy, mv_valid, mv_x, mv_y, min_sad
    );
endinterface

// File: rtl/me_sad_selector.sv
// Motion-estimation SAD selector: tracks the minimum SAD over a raster-ordered search
// window and presents the winning integer MV plus its SAD over valid/ready.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : me_sad_selector_if.slave (start, sad_valid, sad, mv_ready in;
//          busy, mv_valid, mv_x, mv_y, min_sad out)
// Optional feature macro: ME_ZERO_BIAS_EN -- discounts the zero-MV candidate's SAD by
// ZMV_BIAS (saturating at 0) before comparison, favouring cheap MVD coding.
module me_sad_selector #(
    parameter int unsigned MACRO_DIM  = 16,
    parameter int unsigned SEARCH_DIM = 48,
    parameter int unsigned SAD_W      = 16,
    parameter int unsigned MV_W       = 6,
    parameter int unsigned ZMV_BIAS   = 8
) (
    input  logic              clk,
    input  logic              rst,
    me_sad_selector_if.slave  bus
);
    localparam int unsigned N     = SEARCH_DIM - MACRO_DIM + 1;
    localparam int unsigned HALF  = (N - 1) / 2;
    localparam int unsigned CNT_W = $clog2(N);

`ifdef ME_ZERO_BIAS_EN
    localparam logic BIAS_EN = 1'b1;
`else
    localparam logic BIAS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] best_col;
    logic [CNT_W-1:0] best_row;
    logic [SAD_W-1:0] min_sad;
    logic             busy;
    logic             mv_valid;

    logic             col_last;
    logic             row_last;
    logic             init;
    logic             accept;
    logic             is_zero_mv;
    logic [SAD_W-1:0] biased_sad;
    logic [SAD_W-1:0] cand_sad;

    assign col_last = (col == CNT_W'(N - 1));
    assign row_last = (row == CNT_W'(N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) next_state = SEARCH;
            end
            SEARCH: begin
                if (bus.sad_valid && col_last && row_last) next_state = HOLD;
            end
            HOLD: begin
                if (bus.mv_ready) next_state = bus.start ? SEARCH : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath control strobes decoded from the state
    always_comb begin
        init   = 1'b0;
        accept = 1'b0;
        case (state)
            IDLE:    init   = bus.start;
            SEARCH:  accept = bus.sad_valid;
            HOLD:    init   = bus.mv_ready && bus.start;
            default: begin
                init   = 1'b0;
                accept = 1'b0;
            end
        endcase
    end

    // Candidate SAD as seen by the comparator; only the zero-MV position is discounted
    always_comb begin
        is_zero_mv = (col == CNT_W'(HALF)) && (row == CNT_W'(HALF));
        biased_sad = (bus.sad > SAD_W'(ZMV_BIAS)) ? (bus.sad - SAD_W'(ZMV_BIAS)) : '0;
        cand_sad   = (BIAS_EN && is_zero_mv) ? biased_sad : bus.sad;
    end

    // Counters, running minimum and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            best_col <= CNT_W'(HALF);
            best_row <= CNT_W'(HALF);
            min_sad  <= '0;
            busy     <= 1'b0;
            mv_valid <= 1'b0;
        end else begin
            busy     <= (next_state != IDLE);
            mv_valid <= (next_state == HOLD);
            if (init) begin
                col      <= '0;
                row      <= '0;
                best_col <= '0;
                best_row <= '0;
                min_sad  <= '1;
            end else if (accept) begin
                // strict compare: ties keep the earlier raster candidate
                if (cand_sad < min_sad) begin
                    min_sad  <= cand_sad;
                    best_col <= col;
                    best_row <= row;
                end
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + CNT_W'(1);
                end else begin
                    col <= col + CNT_W'(1);
                end
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.mv_valid = mv_valid;
    assign bus.min_sad  = min_sad;
    assign bus.mv_x     = MV_W'(best_col) - MV_W'(HALF);
    assign bus.mv_y     = MV_W'(best_row) - MV_W'(HALF);
endmodule
